// File: rtl/novacore_cfg_loader.sv
// ---------------------------------------------------------------------------
// novacore_cfg_loader
//
// Configuration sequencer for an N x N NovaCORE fabric. Words arrive on a
// valid/ready stream and are replayed onto the fabric configuration port one
// unit at a time: each word is presented on c_bus/c_uid and strobed with a
// slow c_clk pulse. After NUM_UNITS words the loader advances to the next
// configuration dimension with a c_dimswitch-qualified c_clk pulse. When every
// dimension is loaded, mode is raised to hand the fabric over to run operation.
//
// Optional feature (macro NOVACORE_CFG_CHECKSUM_EN):
//   A running XOR of every accepted word is kept. After the last word, one
//   extra trailer word is accepted in state CHK and compared with the running
//   XOR. A mismatch raises err (sticky until the next start) and keeps mode
//   at 0. Without the macro there is no CHK state and err stays 0.
//
// Parameters:
//   BUS_W      configuration word width (c_bus, s_data)
//   UID_W      unit-id width (c_uid)
//   NUM_UNITS  configurable units per dimension (<= 2**UID_W)
//   NUM_DIMS   configuration dimensions, 1..4
//   CLK_HALF   system-clock cycles per c_clk half-period (>= 1)
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   start          one-cycle request to begin a full load (ignored unless idle)
//   s_valid/s_ready/s_data  configuration word stream
//   busy           load in progress
//   done           one-cycle pulse when a load completes
//   err            checksum mismatch (always 0 without the checksum feature)
//   mode           0 = configuration mode, 1 = run mode
//   c_bus, c_uid, c_clk, c_dimension, c_dimswitch  fabric configuration port
// ---------------------------------------------------------------------------
module novacore_cfg_loader #(
    parameter int BUS_W     = 42,
    parameter int UID_W     = 7,
    parameter int NUM_UNITS = 25,
    parameter int NUM_DIMS  = 4,
    parameter int CLK_HALF  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BUS_W-1:0] s_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mode,
    output logic [BUS_W-1:0] c_bus,
    output logic [UID_W-1:0] c_uid,
    output logic             c_clk,
    output logic [1:0]       c_dimension,
    output logic             c_dimswitch
);

    // Counter widths are the minimum that hold the terminal values.
    localparam int UID_CW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int HC_W   = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

    localparam logic [UID_CW-1:0] UID_LAST  = UID_CW'(NUM_UNITS - 1);
    localparam logic [1:0]        DIM_LAST  = 2'(NUM_DIMS - 1);
    localparam logic [HC_W-1:0]   HALF_LAST = HC_W'(CLK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_LOW    = 3'd2,
        S_HIGH   = 3'd3,
        S_SWLOW  = 3'd4,
        S_SWHIGH = 3'd5,
        S_DONE   = 3'd6
`ifdef NOVACORE_CFG_CHECKSUM_EN
        ,
        S_CHK    = 3'd7
`endif
    } state_t;

    state_t state_q, state_d;

    logic [UID_CW-1:0] uid_q, uid_d;
    logic [1:0]        dim_q, dim_d;
    logic [HC_W-1:0]   half_q, half_d;

    logic [BUS_W-1:0]  c_bus_q, c_bus_d;
    logic [UID_W-1:0]  c_uid_q, c_uid_d;
    logic [1:0]        c_dim_q, c_dim_d;
    logic              c_clk_q, c_clk_d;
    logic              c_dimswitch_q, c_dimswitch_d;

    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mode_q, mode_d;
    logic              err_q, err_d;

`ifdef NOVACORE_CFG_CHECKSUM_EN
    logic [BUS_W-1:0]  xsum_q, xsum_d;
`endif

    logic              accept;

    // A word is taken only in a ready state; s_ready_q is high exactly in
    // WAIT (and CHK), so this also qualifies the state.
    assign accept = s_valid && s_ready_q;

    // State register. Reset returns the loader to IDLE from anywhere; there
    // is no attempt to resume a partially loaded fabric.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath logic. Counters and captured fabric values
    // hold by default; the per-state branches only describe changes.
    // Strobe-type outputs are decoded from the next state so that their
    // registered copies line up exactly with the state they belong to.
    always_comb begin
        state_d  = state_q;
        uid_d    = uid_q;
        dim_d    = dim_q;
        half_d   = half_q;
        c_bus_d  = c_bus_q;
        c_uid_d  = c_uid_q;
        c_dim_d  = c_dim_q;
        mode_d   = mode_q;
        err_d    = err_q;
`ifdef NOVACORE_CFG_CHECKSUM_EN
        xsum_d   = xsum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    uid_d   = '0;
                    dim_d   = '0;
                    half_d  = '0;
                    c_dim_d = '0;
                    mode_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef NOVACORE_CFG_CHECKSUM_EN
                    xsum_d  = '0;
`endif
                end
            end

            S_WAIT: begin
                if (accept) begin
                    c_bus_d = s_data;
                    c_uid_d = UID_W'(uid_q);
                    half_d  = '0;
                    state_d = S_LOW;
`ifdef NOVACORE_CFG_CHECKSUM_EN
                    xsum_d  = xsum_q ^ s_data;
`endif
                end
            end

            S_LOW: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    state_d = S_HIGH;
                end else begin
                    half_d = half_q + HC_W'(1);
                end
            end

            // End of the word strobe decides between the next unit, a
            // dimension switch, or the end of the load.
            S_HIGH: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    if (uid_q != UID_LAST) begin
                        uid_d   = uid_q + UID_CW'(1);
                        state_d = S_WAIT;
                    end else if (dim_q != DIM_LAST) begin
                        uid_d   = '0;
                        dim_d   = dim_q + 2'd1;
                        c_dim_d = dim_q + 2'd1;
                        state_d = S_SWLOW;
                    end else begin
`ifdef NOVACORE_CFG_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
                        mode_d  = 1'b1;
`endif
                    end
                end else begin
                    half_d = half_q + HC_W'(1);
                end
            end

            S_SWLOW: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    state_d = S_SWHIGH;
                end else begin
                    half_d = half_q + HC_W'(1);
                end
            end

            S_SWHIGH: begin
                if (half_q == HALF_LAST) begin
                    half_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    half_d = half_q + HC_W'(1);
                end
            end

`ifdef NOVACORE_CFG_CHECKSUM_EN
            // The trailer word is compared but never presented to the
            // fabric, so c_bus and c_clk are left alone here.
            S_CHK: begin
                if (accept) begin
                    state_d = S_DONE;
                    if (s_data != xsum_q) begin
                        err_d  = 1'b1;
                        mode_d = 1'b0;
                    end else begin
                        mode_d = 1'b1;
                    end
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef NOVACORE_CFG_CHECKSUM_EN
        s_ready_d = (state_d == S_WAIT) || (state_d == S_CHK);
`else
        s_ready_d = (state_d == S_WAIT);
`endif
        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d        = (state_d == S_DONE);
        c_clk_d       = (state_d == S_HIGH) || (state_d == S_SWHIGH);
        c_dimswitch_d = (state_d == S_SWLOW) || (state_d == S_SWHIGH);
    end

    // Counters, captured fabric values and registered status outputs.
    // Everything clears on reset so the fabric port goes quiet immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uid_q         <= '0;
            dim_q         <= '0;
            half_q        <= '0;
            c_bus_q       <= '0;
            c_uid_q       <= '0;
            c_dim_q       <= '0;
            c_clk_q       <= 1'b0;
            c_dimswitch_q <= 1'b0;
            s_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mode_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            uid_q         <= uid_d;
            dim_q         <= dim_d;
            half_q        <= half_d;
            c_bus_q       <= c_bus_d;
            c_uid_q       <= c_uid_d;
            c_dim_q       <= c_dim_d;
            c_clk_q       <= c_clk_d;
            c_dimswitch_q <= c_dimswitch_d;
            s_ready_q     <= s_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mode_q        <= mode_d;
            err_q         <= err_d;
        end
    end

`ifdef NOVACORE_CFG_CHECKSUM_EN
    // Running XOR of the accepted configuration words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xsum_q <= '0;
        end else begin
            xsum_q <= xsum_d;
        end
    end
`endif

    assign s_ready     = s_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mode        = mode_q;
    assign c_bus       = c_bus_q;
    assign c_uid       = c_uid_q;
    assign c_clk       = c_clk_q;
    assign c_dimension = c_dim_q;
    assign c_dimswitch = c_dimswitch_q;

endmodule

// File: tb/tb_novacore_cfg_loader.sv
module tb_novacore_cfg_loader;

    localparam int BUS_W = 42;
    localparam int UID_W = 7;
    localparam int NU    = 25;
    localparam int ND    = 4;
    localparam int CH    = 2;
    localparam int NWORD = NU * ND;

`ifdef NOVACORE_CFG_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    typedef struct {
        logic [BUS_W-1:0] data;
        logic [UID_W-1:0] uid;
        logic [1:0]       dim;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             s_valid;
    logic             s_ready;
    logic [BUS_W-1:0] s_data;
    logic             busy, done, err, mode;
    logic [BUS_W-1:0] c_bus;
    logic [UID_W-1:0] c_uid;
    logic             c_clk;
    logic [1:0]       c_dimension;
    logic             c_dimswitch;

    logic             start2;
    logic             s_ready2;
    logic             busy2, done2, err2, mode2;
    logic [BUS_W-1:0] c_bus2;
    logic [UID_W-1:0] c_uid2;
    logic             c_clk2;
    logic [1:0]       c_dim2;
    logic             c_dimswitch2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   strobes, switches, sw_len, done_cnt;
    logic prev_clk;
    int   strobes2, sw2;
    logic prev_clk2;
    int   start_cyc;

    novacore_cfg_loader #(
        .BUS_W(BUS_W), .UID_W(UID_W), .NUM_UNITS(NU), .NUM_DIMS(ND), .CLK_HALF(CH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .busy(busy), .done(done), .err(err), .mode(mode),
        .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk), .c_dimension(c_dimension),
        .c_dimswitch(c_dimswitch)
    );

    // Small 3-unit, single-dimension build with the fastest strobe.
    novacore_cfg_loader #(
        .BUS_W(BUS_W), .UID_W(UID_W), .NUM_UNITS(3), .NUM_DIMS(1), .CLK_HALF(1)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .s_valid(1'b1), .s_ready(s_ready2),
        .s_data(42'h15), .busy(busy2), .done(done2), .err(err2), .mode(mode2),
        .c_bus(c_bus2), .c_uid(c_uid2), .c_clk(c_clk2), .c_dimension(c_dim2),
        .c_dimswitch(c_dimswitch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [BUS_W-1:0] word_of(input int run, input int k);
        word_of = (42'(run) << 34) | 42'(k * 7 + 3);
    endfunction

    // Word strobes pop the scoreboard; dimension switches are timed.
    always @(negedge clk) begin
        if (c_clk && !prev_clk) begin
            if (!c_dimswitch) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    checkOutput("extra_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("c_bus", c_bus, mon_e.data);
                    checkOutput("c_uid", c_uid, mon_e.uid);
                    checkOutput("c_dim", c_dimension, mon_e.dim);
                end
            end else begin
                switches++;
            end
        end
        if (c_dimswitch) begin
            sw_len++;
        end else if (sw_len != 0) begin
            checkOutput("sw_len", sw_len, 2 * CH);
            sw_len = 0;
        end
        if (done) done_cnt++;
        prev_clk = c_clk;
    end

    always @(negedge clk) begin
        if (c_clk2 && !prev_clk2) strobes2++;
        if (c_dimswitch2) sw2++;
        prev_clk2 = c_clk2;
    end

    task automatic checkReset(input string tag);
        checkOutput({tag, "_s_ready"}, s_ready, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_mode"}, mode, 0);
        checkOutput({tag, "_c_bus"}, c_bus, 0);
        checkOutput({tag, "_c_uid"}, c_uid, 0);
        checkOutput({tag, "_c_clk"}, c_clk, 0);
        checkOutput({tag, "_c_dim"}, c_dimension, 0);
        checkOutput({tag, "_c_dimsw"}, c_dimswitch, 0);
    endtask

    // One full load: bp_at drops s_valid for 10 cycles after that word,
    // inj_at pulses start while that word is handed over, rst_at resets the
    // loader during that word's high phase and ends the load.
    task automatic applyStimulus(input int run, input int bp_at, input int inj_at,
                                 input int rst_at, input bit bad_trailer, output int lat);
        int n;
        logic [BUS_W-1:0] acc;
        exp_t e;
        acc      = '0;
        lat      = -1;
        strobes  = 0;
        switches = 0;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        for (int k = 0; k < NWORD; k++) begin
            s_valid = 1'b1;
            s_data  = word_of(run, k);
            n = 0;
            while (!s_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!s_ready) begin
                checkOutput("ready_timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            e.data = s_data;
            e.uid  = UID_W'(k % NU);
            e.dim  = 2'(k / NU);
            exp_q.push_back(e);
            acc = acc ^ s_data;
            if (k == inj_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (k == inj_at) checkOutput("busy_inj", busy, 1);
            if (k == bp_at) begin
                s_valid = 1'b0;
                s_data  = ~word_of(run, k);
                repeat (10) @(negedge clk);
                checkOutput("bp_c_clk", c_clk, 0);
                checkOutput("bp_c_bus", c_bus, word_of(run, k));
                checkOutput("bp_ready", s_ready, 1);
                checkOutput("bp_strobes", strobes, k + 1);
            end
            if (k == rst_at) begin
                n = 0;
                while (!c_clk && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("rst_in_high", c_clk, 1);
                checkOutput("rst_dim", c_dimension, 2'(k / NU));
                #1 rst_n = 1'b0;
                s_valid = 1'b0;
                #1 checkReset("midrst");
                return;
            end
        end
`ifdef NOVACORE_CFG_CHECKSUM_EN
        s_valid = 1'b1;
        s_data  = bad_trailer ? (acc ^ 42'h1) : acc;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("chk_ready", s_ready, 1);
        @(negedge clk);
`endif
        s_valid = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", done, 1);
        lat = cyc - start_cyc;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        rst_n   = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        prev_clk  = 1'b0;
        prev_clk2 = 1'b0;
        sw_len  = 0;
        strobes2 = 0;
        sw2      = 0;
        repeat (2) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Run 1: continuous stream.
        applyStimulus(1, -1, -1, -1, 1'b0, lat);
        checkOutput("r1_latency", lat, 512 + CHK_EXTRA);
        checkOutput("r1_strobes", strobes, NWORD);
        checkOutput("r1_switches", switches, ND - 1);
        checkOutput("r1_err", err, 0);
        checkOutput("r1_busy", busy, 0);
        checkOutput("r1_final_dim", c_dimension, ND - 1);
        @(negedge clk);
        checkOutput("r1_mode", mode, 1);
        checkOutput("r1_done_cnt", done_cnt, 1);
        checkOutput("r1_queue", exp_q.size(), 0);

        // Run 2: backpressure, start during load and during DONE.
        applyStimulus(2, 7, 50, -1, 1'b1, lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("r2_busy", busy, 0);
        checkOutput("r2_done_low", done, 0);
        checkOutput("r2_mode", mode, CHK_EXTRA ? 0 : 1);
        checkOutput("r2_err", err, CHK_EXTRA);
        repeat (3) @(negedge clk);
        checkOutput("r2_busy_late", busy, 0);
        checkOutput("r2_ready_late", s_ready, 0);
        checkOutput("r2_strobes", strobes, NWORD);
        checkOutput("r2_done_cnt", done_cnt, 1);
        checkOutput("r2_queue", exp_q.size(), 0);

        // Run 3: asynchronous reset in word 40's high phase, then reload.
        applyStimulus(3, -1, -1, 40, 1'b0, lat);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        applyStimulus(4, -1, -1, -1, 1'b0, lat);
        checkOutput("r4_latency", lat, 512 + CHK_EXTRA);
        checkOutput("r4_strobes", strobes, NWORD);
        checkOutput("r4_switches", switches, ND - 1);
        @(negedge clk);
        checkOutput("r4_mode", mode, 1);
        checkOutput("r4_queue", exp_q.size(), 0);

        // Small build: 3 words, single dimension, CLK_HALF=1.
        strobes2 = 0;
        sw2      = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("small_latency", n, 9 + CHK_EXTRA);
        checkOutput("small_strobes", strobes2, 3);
        checkOutput("small_dimsw", sw2, 0);
        @(negedge clk);
        checkOutput("small_mode", mode2, 1);
        checkOutput("small_err", err2, 0);
        checkOutput("small_busy", busy2, 0);
        checkOutput("small_uid", c_uid2, 2);
        checkOutput("small_bus", c_bus2, 42'h15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
